// File: rtl/pic_ack_initiator.sv
// pic_ack_initiator
//   CPU-side initiator of the 8259A interrupt-acknowledge protocol. It watches
//   the PIC INT line and generates INTA_n pulses with exact timing: two pulses
//   in 8086 mode and three in MCS-80 mode. On each pulse it samples the PIC
//   data bus, then presents the vector or CALL address on a valid/ready
//   handshake.
//
// Ports
//   clock                   system clock, rising-edge active
//   reset                   asynchronous active-high reset
//   interrupt_to_cpu        INT from the PIC (asynchronous, synchronised here)
//   enable                  permits a new acknowledge sequence to start
//   u8086_mode              1 = 8086 (2 pulses), 0 = MCS-80 (3 pulses)
//   data_bus_in             PIC data bus, sampled on the last low clock of a pulse
//   interrupt_acknowledge_n INTA_n to the PIC, active low
//   busy                    acknowledge sequence in progress
//   result_valid            result registers hold a completed sequence
//   result_ready            consumer accepts the result
//   result_8086             mode that produced the held result
//   vector_out              8086 vector byte (second pulse)
//   call_opcode             MCS-80 first byte (normally 8'hCD)
//   call_address            MCS-80 address {third byte, second byte}
module pic_ack_initiator #(
  parameter int INTA_LOW_CYCLES  = 4,
  parameter int INTA_HIGH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        interrupt_to_cpu,
  input  logic        enable,
  input  logic        u8086_mode,
  input  logic [7:0]  data_bus_in,
  output logic        interrupt_acknowledge_n,
  output logic        busy,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        result_8086,
  output logic [7:0]  vector_out,
  output logic [7:0]  call_opcode,
  output logic [15:0] call_address
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK_LOW  = 2'd1,
    ACK_HIGH = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Phase timers count from zero, so the terminal value is length minus one.
  localparam logic [3:0] LOW_LAST  = 4'(INTA_LOW_CYCLES - 1);
  localparam logic [3:0] HIGH_LAST = 4'(INTA_HIGH_CYCLES - 1);

  state_t     state_r;
  logic       int_meta_r;
  logic       int_sync_r;
  logic       mode_l_r;
  logic [1:0] pulse_cnt_r;
  logic [3:0] timer_r;
  logic       last_pulse_s;

  // Two-flop synchroniser for the asynchronous INT line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      int_meta_r <= 1'b0;
      int_sync_r <= 1'b0;
    end else begin
      int_meta_r <= interrupt_to_cpu;
      int_sync_r <= int_meta_r;
    end
  end

  // Final pulse of the sequence depends on the mode latched at its start.
  always_comb begin
    last_pulse_s = 1'b0;
    if (mode_l_r) begin
      last_pulse_s = (pulse_cnt_r == 2'd1);
    end else begin
      last_pulse_s = (pulse_cnt_r == 2'd2);
    end
  end

  // Acknowledge sequencer: pulse timing, byte capture and result handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r                 <= IDLE;
      interrupt_acknowledge_n <= 1'b1;
      busy                    <= 1'b0;
      result_valid            <= 1'b0;
      result_8086             <= 1'b0;
      vector_out              <= 8'h00;
      call_opcode             <= 8'h00;
      call_address            <= 16'h0000;
      mode_l_r                <= 1'b0;
      pulse_cnt_r             <= 2'd0;
      timer_r                 <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          // result_valid is checked explicitly so an unconsumed result can
          // never be overwritten, even if the state encoding is disturbed.
          if (int_sync_r && enable && !result_valid) begin
            state_r                 <= ACK_LOW;
            interrupt_acknowledge_n <= 1'b0;
            busy                    <= 1'b1;
            pulse_cnt_r             <= 2'd0;
            timer_r                 <= 4'd0;
            mode_l_r                <= u8086_mode;
          end else begin
            state_r <= IDLE;
          end
        end

        ACK_LOW: begin
          if (timer_r == LOW_LAST) begin
            // Data is taken on the edge that closes the low phase, when the
            // PIC has had the whole pulse to drive the bus.
            case ({mode_l_r, pulse_cnt_r})
              3'b1_01: vector_out          <= data_bus_in;
              3'b0_00: call_opcode         <= data_bus_in;
              3'b0_01: call_address[7:0]   <= data_bus_in;
              3'b0_10: call_address[15:8]  <= data_bus_in;
              default: vector_out          <= vector_out;
            endcase
            interrupt_acknowledge_n <= 1'b1;
            timer_r                 <= 4'd0;
            if (last_pulse_s) begin
              state_r      <= DONE;
              result_valid <= 1'b1;
              busy         <= 1'b0;
              result_8086  <= mode_l_r;
            end else begin
              state_r <= ACK_HIGH;
            end
          end else begin
            timer_r <= timer_r + 4'd1;
          end
        end

        ACK_HIGH: begin
          if (timer_r == HIGH_LAST) begin
            state_r                 <= ACK_LOW;
            interrupt_acknowledge_n <= 1'b0;
            pulse_cnt_r             <= pulse_cnt_r + 2'd1;
            timer_r                 <= 4'd0;
          end else begin
            timer_r <= timer_r + 4'd1;
          end
        end

        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state_r      <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end

        default: begin
          // Unreachable encoding: return to a safe, idle bus state.
          state_r                 <= IDLE;
          interrupt_acknowledge_n <= 1'b1;
          busy                    <= 1'b0;
          result_valid            <= 1'b0;
          timer_r                 <= 4'd0;
          pulse_cnt_r             <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pic_ack_initiator.sv
// Testbench for pic_ack_initiator: directed stimulus with a scoreboard of
// expected results and an independent monitor for INTA_n timing and results.
module tb_pic_ack_initiator;

  localparam int LOW  = 4;
  localparam int HIGH = 2;

  typedef struct {
    logic        mode;
    logic [7:0]  vec;
    logic [7:0]  op;
    logic [15:0] addr;
  } exp_t;

  logic        clock            = 1'b0;
  logic        reset            = 1'b1;
  logic        interrupt_to_cpu = 1'b0;
  logic        enable           = 1'b0;
  logic        u8086_mode       = 1'b0;
  logic        result_ready     = 1'b0;
  logic [7:0]  data_bus_in      = 8'h00;
  logic        interrupt_acknowledge_n;
  logic        busy;
  logic        result_valid;
  logic        result_8086;
  logic [7:0]  vector_out;
  logic [7:0]  call_opcode;
  logic [15:0] call_address;

  int   checks = 0;
  int   errors = 0;
  logic [7:0] pic_bytes [0:2];
  exp_t sb_q [$];

  pic_ack_initiator #(
    .INTA_LOW_CYCLES (LOW),
    .INTA_HIGH_CYCLES(HIGH)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .interrupt_to_cpu       (interrupt_to_cpu),
    .enable                 (enable),
    .u8086_mode             (u8086_mode),
    .data_bus_in            (data_bus_in),
    .interrupt_acknowledge_n(interrupt_acknowledge_n),
    .busy                   (busy),
    .result_valid           (result_valid),
    .result_ready           (result_ready),
    .result_8086            (result_8086),
    .vector_out             (vector_out),
    .call_opcode            (call_opcode),
    .call_address           (call_address)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT event did not occur within the cycle budget at %0t", name, $time);
  endtask

  // PIC model: on each INTA_n fall drive the next byte of the current sequence.
  logic pic_prev_inta = 1'b1;
  logic pic_prev_busy = 1'b0;
  int   pic_idx       = 0;
  always @(negedge clock) begin
    if (pic_prev_inta && !interrupt_acknowledge_n) begin
      if (!pic_prev_busy) pic_idx = 0;
      else if (pic_idx < 2) pic_idx = pic_idx + 1;
      data_bus_in = pic_bytes[pic_idx];
    end
    pic_prev_inta = (interrupt_acknowledge_n !== 1'b0);
    pic_prev_busy = (busy === 1'b1);
  end

  // Monitor: INTA_n pulse/gap lengths, pulse count, and scoreboard compare.
  logic m_prev_inta = 1'b1;
  logic m_prev_busy = 1'b0;
  logic m_prev_rv   = 1'b0;
  int   m_pulses    = 0;
  int   m_low_run   = 0;
  int   m_high_run  = 0;
  exp_t m_exp;
  always @(negedge clock) begin
    if (reset) begin
      m_prev_inta = 1'b1;
      m_prev_busy = 1'b0;
      m_prev_rv   = 1'b0;
      m_pulses    = 0;
      m_low_run   = 0;
      m_high_run  = 0;
    end else begin
      if (m_prev_inta && !interrupt_acknowledge_n) begin
        if (!m_prev_busy) begin
          m_pulses = 1;
        end else begin
          check("inta_high_len", m_high_run, HIGH);
          m_pulses = m_pulses + 1;
        end
        check("busy_during_pulse", busy, 1'b1);
        m_low_run = 1;
      end else if (!m_prev_inta && interrupt_acknowledge_n) begin
        check("inta_low_len", m_low_run, LOW);
        m_high_run = 1;
      end else if (!interrupt_acknowledge_n) begin
        m_low_run = m_low_run + 1;
      end else begin
        m_high_run = m_high_run + 1;
      end

      if (result_valid && !m_prev_rv) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: result_valid=1 required=0 at %0t", $time);
        end else begin
          m_exp = sb_q.pop_front();
          check("rv_on_inta_rise", {m_prev_inta, interrupt_acknowledge_n}, 2'b01);
          check("pulse_count", m_pulses, m_exp.mode ? 2 : 3);
          check("result_8086", result_8086, m_exp.mode);
          check("busy_at_done", busy, 1'b0);
          if (m_exp.mode) begin
            check("vector_out", vector_out, m_exp.vec);
          end else begin
            check("call_opcode", call_opcode, m_exp.op);
            check("call_address", call_address, m_exp.addr);
          end
        end
      end
      m_prev_inta = interrupt_acknowledge_n;
      m_prev_busy = busy;
      m_prev_rv   = result_valid;
    end
  end

  task automatic wait_rv(input string name);
    int n = 0;
    while (result_valid !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (result_valid !== 1'b1) timeout_fail(name);
  endtask

  task automatic wait_inta_rises(input int cnt, input string name);
    int   seen = 0;
    int   k    = 0;
    logic prev = interrupt_acknowledge_n;
    while (seen < cnt && k < 200) begin
      @(negedge clock);
      k++;
      if (!prev && interrupt_acknowledge_n) seen++;
      prev = interrupt_acknowledge_n;
    end
    if (seen < cnt) timeout_fail(name);
  endtask

  task automatic wait_inta_fall(input string name);
    int k = 0;
    while (interrupt_acknowledge_n !== 1'b0 && k < 200) begin
      @(negedge clock);
      k++;
    end
    if (interrupt_acknowledge_n !== 1'b0) timeout_fail(name);
  endtask

  // Drop INT long enough to clear the synchroniser, then consume the result.
  task automatic accept(input string name);
    interrupt_to_cpu = 1'b0;
    repeat (3) @(negedge clock);
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    check({name, "_rv_clear"}, result_valid, 1'b0);
    @(negedge clock);
    check({name, "_no_restart"}, interrupt_acknowledge_n, 1'b1);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_inta_n"}, interrupt_acknowledge_n, 1'b1);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_rv"}, result_valid, 1'b0);
    check({name, "_r8086"}, result_8086, 1'b0);
    check({name, "_vector"}, vector_out, 8'h00);
    check({name, "_opcode"}, call_opcode, 8'h00);
    check({name, "_address"}, call_address, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    pic_bytes[0] = 8'h00;
    pic_bytes[1] = 8'h00;
    pic_bytes[2] = 8'h00;

    // Reset state, then 50 idle cycles with INT low.
    repeat (3) @(negedge clock);
    check_reset_values("reset_held");
    reset = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      check("idle_inta_n", interrupt_acknowledge_n, 1'b1);
      check("idle_busy", busy, 1'b0);
      check("idle_rv", result_valid, 1'b0);
    end

    // 8086: pulse0 byte discarded, pulse1 byte becomes the vector.
    pic_bytes[0] = 8'hFF; pic_bytes[1] = 8'h4A;
    u8086_mode = 1'b1;
    e = '{mode: 1'b1, vec: 8'h4A, op: 8'h00, addr: 16'h0000};
    sb_q.push_back(e);
    interrupt_to_cpu = 1'b1;
    wait_rv("rv_8086");
    accept("acc_8086");

    // MCS-80: three bytes form CALL opcode and address.
    pic_bytes[0] = 8'hCD; pic_bytes[1] = 8'h20; pic_bytes[2] = 8'h3F;
    u8086_mode = 1'b0;
    e = '{mode: 1'b0, vec: 8'h00, op: 8'hCD, addr: 16'h3F20};
    sb_q.push_back(e);
    interrupt_to_cpu = 1'b1;
    wait_rv("rv_mcs80");
    accept("acc_mcs80");

    // MCS-80 with INT, enable dropped and mode flipped after pulse1.
    pic_bytes[0] = 8'hCD; pic_bytes[1] = 8'h34; pic_bytes[2] = 8'h12;
    u8086_mode = 1'b0;
    e = '{mode: 1'b0, vec: 8'h00, op: 8'hCD, addr: 16'h1234};
    sb_q.push_back(e);
    interrupt_to_cpu = 1'b1;
    wait_inta_rises(2, "pulse1_end");
    interrupt_to_cpu = 1'b0;
    enable = 1'b0;
    u8086_mode = 1'b1;
    wait_rv("rv_dropped");
    accept("acc_dropped");
    enable = 1'b1;

    // Held result with INT high: no new pulse until result_ready.
    pic_bytes[0] = 8'h00; pic_bytes[1] = 8'h99;
    u8086_mode = 1'b1;
    e = '{mode: 1'b1, vec: 8'h99, op: 8'h00, addr: 16'h0000};
    sb_q.push_back(e);
    interrupt_to_cpu = 1'b1;
    wait_rv("rv_hold");
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("hold_inta_n", interrupt_acknowledge_n, 1'b1);
      check("hold_rv", result_valid, 1'b1);
      check("hold_vector", vector_out, 8'h99);
      check("hold_r8086", result_8086, 1'b1);
    end
    pic_bytes[0] = 8'h11; pic_bytes[1] = 8'h5C;
    e = '{mode: 1'b1, vec: 8'h5C, op: 8'h00, addr: 16'h0000};
    sb_q.push_back(e);
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    check("handshake_rv_clear", result_valid, 1'b0);
    check("handshake_inta_idle", interrupt_acknowledge_n, 1'b1);
    @(negedge clock);
    check("restart_inta_low", interrupt_acknowledge_n, 1'b0);
    check("restart_busy", busy, 1'b1);
    interrupt_to_cpu = 1'b0;
    wait_rv("rv_back_to_back");
    accept("acc_back_to_back");

    // Reset in the middle of an ACK_LOW phase.
    pic_bytes[0] = 8'hCD; pic_bytes[1] = 8'h01; pic_bytes[2] = 8'h02;
    u8086_mode = 1'b0;
    interrupt_to_cpu = 1'b1;
    wait_inta_fall("reset_test_start");
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("mid_reset");
    interrupt_to_cpu = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      check("post_reset_rv", result_valid, 1'b0);
      check("post_reset_inta_n", interrupt_acknowledge_n, 1'b1);
    end

    check("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
